arcade_input_mapper: RTL and testbench
======================================

Name: arcade_input_mapper

Overview:
Parametrised input front-end for arcade cores.
- Decodes PS/2 key events against a runtime-loadable keymap and merges them with HPS joystick vectors for up to 4 players.
- Captures DIP-switch bytes and the game index from the ioctl stream.
- Adds coin-pulse stretching and a latched pause toggle.
- Sits between hps_io and the game module; its outputs drive the game's joystick, button, sys, pause and DIP inputs directly.

Parameters:
PLAYERS, 2, number of players (1..4)
BUTTONS, 3, action buttons per player (1..8); per-player control width J = BUTTONS+7
DIP_BYTES, 8, number of DIP bytes captured (1..8)
COIN_CYCLES, 16384, minimum clk cycles coin output stays high after a press
KEYMAP_INDEX, 253, ioctl_index that carries keymap bytes

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
ps2_key  in  11  [10] event toggle, [9] pressed, [7:0] scan code
joy_in  in  PLAYERS*J  HPS joystick vectors, player p at [p*J +: J]
ioctl_wr  in  1  download byte strobe
ioctl_index  in  8  download index
ioctl_addr  in  25  download byte address
ioctl_data  in  8  download byte
vsync  in  1  video vsync (used only with AUTOFIRE_EN)
ctrl_out  out  PLAYERS*J  merged controls, same layout as joy_in
pause  out  1  latched pause state
game_index  out  4  selected game
dip_out  out  DIP_BYTES*8  DIP bytes, byte n at [n*8 +: 8]

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset.
- Control bit order within J:
  - 0 right, 1 left, 2 down, 3 up
  - 4..BUTTONS+3 buttons
  - BUTTONS+4 start, BUTTONS+5 coin, BUTTONS+6 pause
- Keymap: PLAYERS*J bytes, entry e = p*J + bit.
  - Code 0x00 means unmapped and never matches.
  - Power-up defaults, P1 in bit order: 74 6B 72 75 14 11 29 16 2E 4D.
  - Power-up defaults, P2 in bit order: 34 23 2B 2D 1C 1B 15 1E 36 00.
  - Extra buttons and players 3-4 default to 00.
- Key event detection: a registered old_toggle compares against ps2_key[10].
  - On mismatch, every keymap entry equal to ps2_key[7:0] sets its key_state bit to ps2_key[9]. All matching entries update in parallel; one code may drive several controls.
  - ps2_key[8] is ignored.
- Timing:
  - ctrl_out is registered: ctrl_out = joy_in | key_state, with the coin bit replaced by the stretched coin.
  - Joystick-to-output latency is 1 cycle.
  - Key-event-to-output latency is 2 edges after ps2_key[10] toggles.
- Coin stretcher, per player: a rising edge of raw coin (joy|key) loads a counter with COIN_CYCLES-1.
  - Coin output is high while the counter is nonzero or raw coin is high.
  - A rising edge while the counter is running reloads it.
- Pause: a rising edge of OR of all raw pause bits toggles pause. Raw pause bits also pass to ctrl_out.
- ioctl, evaluated on ioctl_wr only:
  - index 1: game_index <= data[3:0].
  - index 254 with addr < DIP_BYTES: dip byte[addr] <= data.
  - index KEYMAP_INDEX with addr < PLAYERS*J: keymap[addr] <= data, and all key_state bits clear that same cycle.
  - Out-of-range addresses are ignored.
- Same-cycle key event and keymap write: the clear wins, and the event is discarded.
- Reset:
  - Cleared to 0: key_state, ctrl_out, coin counters, pause, edge-detect registers; old_toggle <= ps2_key[10].
  - Not affected: keymap, dip_out, game_index.
  - Power-up values: dip_out = 0, game_index = 0.
- Reset asserted mid-stretch kills coin output on the next edge.

Optional Feature:
AUTOFIRE_EN
- Defined:
  - Adds input autofire (PLAYERS bits) and parameter AUTOFIRE_FRAMES, default 3.
  - When autofire[p] is set and player p's button 1 is held, its ctrl_out bit toggles every AUTOFIRE_FRAMES vsync rising edges, starting high.
  - Releasing the button forces the bit low and resets the phase.
- Undefined: the port is absent, vsync is unused, and button 1 passes through unmodified.

Test Plan:
- ps2_key toggle with [9]=1, code 0x14 -> ctrl_out[4]=1 two edges later; toggle with [9]=0, code 0x14 -> ctrl_out[4]=0.
- joy_in[1*10+7]=1 (P2 start) -> ctrl_out[17]=1 after 1 cycle; key 0x2E press then release after 10 cycles, COIN_CYCLES=100 -> ctrl_out[8] high for exactly 100 cycles from rise.
- Press, release, press key 0x4D -> pause goes 0->1->0 per rising edge; reset mid-way -> pause=0.
- ioctl index 253, addr 4, data 0x1A while key 0x14 is held -> key_state cleared; press 0x1A -> ctrl_out[4]=1; press 0x14 -> no change.
- ioctl index 254, addr 0..1 = 0xA5, 0x3C; addr 9 = 0xFF -> dip_out[15:0]=0x3CA5, no other byte changes; index 1, data 0x07 -> game_index=7, preserved across reset.
- Key 0x14 event and keymap write in the same cycle -> key_state all zero, event lost.

Source files
------------

// File: rtl/arcade_input_mapper.sv
// rtl/arcade_input_mapper.sv - PS/2 keymap and joystick merge with coin stretch, pause toggle, DIP/game capture
// Optional feature macro: AUTOFIRE_EN (vsync-paced autofire on button 1).
module arcade_input_mapper #(
    parameter int PLAYERS      = 2,
    parameter int BUTTONS      = 3,
    parameter int DIP_BYTES    = 8,
    parameter int COIN_CYCLES  = 16384,
    parameter int KEYMAP_INDEX = 253
`ifdef AUTOFIRE_EN
    ,
    parameter int AUTOFIRE_FRAMES = 3
`endif
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [10:0]                      ps2_key,
    input  logic [PLAYERS*(BUTTONS+7)-1:0]   joy_in,
    input  logic                             ioctl_wr,
    input  logic [7:0]                       ioctl_index,
    input  logic [24:0]                      ioctl_addr,
    input  logic [7:0]                       ioctl_data,
    input  logic                             vsync,
`ifdef AUTOFIRE_EN
    input  logic [PLAYERS-1:0]               autofire,
`endif
    output logic [PLAYERS*(BUTTONS+7)-1:0]   ctrl_out,
    output logic                             pause,
    output logic [3:0]                       game_index,
    output logic [DIP_BYTES*8-1:0]           dip_out
);
    localparam int J       = BUTTONS + 7;
    localparam int N       = PLAYERS * J;
    localparam int CW      = $clog2(COIN_CYCLES + 1);
    localparam int B_FIRE  = 4;
    localparam int B_COIN  = BUTTONS + 5;
    localparam int B_PAUSE = BUTTONS + 6;

    // Table bytes are in control-bit order; buttons beyond the third and players 3-4 stay unmapped.
    function automatic logic [N*8-1:0] f_default_map();
        logic [N*8-1:0] m;
        logic [79:0]    p1;
        logic [79:0]    p2;
        int             src;
        m  = '0;
        p1 = 80'h4D_2E_16_29_11_14_75_72_6B_74;
        p2 = 80'h00_36_1E_15_1B_1C_2D_2B_23_34;
        for (int p = 0; p < PLAYERS && p < 2; p++) begin
            for (int b = 0; b < J; b++) begin
                if (b < 4)                src = b;
                else if (b < BUTTONS + 4) src = (b < 7) ? b : -1;
                else                      src = b - BUTTONS + 3;
                if (src >= 0)
                    m[(p*J+b)*8 +: 8] = (p == 0) ? p1[src*8 +: 8] : p2[src*8 +: 8];
            end
        end
        return m;
    endfunction

    localparam logic [N*8-1:0] DEFAULT_MAP = f_default_map();

    logic [N*8-1:0]         r_keymap = DEFAULT_MAP;
    logic [DIP_BYTES*8-1:0] r_dip = '0;
    logic [3:0]             r_game_index = '0;
    logic [N-1:0]           r_key_state;
    logic                   r_old_toggle;
    logic [PLAYERS-1:0]     r_coin_prev;
    logic [CW-1:0]          r_coin_cnt [PLAYERS];
    logic                   r_pause;
    logic                   r_pause_prev;
    logic [N-1:0]           r_ctrl;

    logic                   w_key_event;
    logic                   w_keymap_wr;
    logic [N-1:0]           w_raw;
    logic [N-1:0]           w_ctrl_next;
    logic                   w_pause_any;
    logic                   w_unused;

    assign w_key_event = ps2_key[10] != r_old_toggle;
    assign w_keymap_wr = ioctl_wr && (ioctl_index == 8'(KEYMAP_INDEX)) && (ioctl_addr < 25'(N));
    assign w_raw       = joy_in | r_key_state;
    assign w_unused    = ^{ps2_key[8], vsync};

    assign ctrl_out   = r_ctrl;
    assign pause      = r_pause;
    assign game_index = r_game_index;
    assign dip_out    = r_dip;

    // Download-stream state is deliberately outside reset so a core reset keeps the loaded config.
    always_ff @(posedge clk) begin
        if (ioctl_wr && ioctl_index == 8'd1)
            r_game_index <= ioctl_data[3:0];
        for (int n = 0; n < DIP_BYTES; n++)
            if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr == 25'(n))
                r_dip[n*8 +: 8] <= ioctl_data;
        for (int e = 0; e < N; e++)
            if (w_keymap_wr && ioctl_addr == 25'(e))
                r_keymap[e*8 +: 8] <= ioctl_data;
    end

    // A keymap write drops held keys; a coincident key event is lost rather than applied to a stale map.
    always_ff @(posedge clk) begin
        r_old_toggle <= ps2_key[10];
        if (reset || w_keymap_wr) begin
            r_key_state <= '0;
        end else if (w_key_event) begin
            for (int e = 0; e < N; e++)
                if (ps2_key[7:0] != 8'h00 && r_keymap[e*8 +: 8] == ps2_key[7:0])
                    r_key_state[e] <= ps2_key[9];
        end
    end

`ifdef AUTOFIRE_EN
    localparam int AW = $clog2(AUTOFIRE_FRAMES + 1);
    logic               r_vs_prev;
    logic [PLAYERS-1:0] r_af_phase;
    logic [AW-1:0]      r_af_cnt [PLAYERS];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vs_prev  <= 1'b0;
            r_af_phase <= '1;
            for (int p = 0; p < PLAYERS; p++) r_af_cnt[p] <= '0;
        end else begin
            r_vs_prev <= vsync;
            for (int p = 0; p < PLAYERS; p++) begin
                if (!(autofire[p] && w_raw[p*J+B_FIRE])) begin
                    r_af_cnt[p]   <= '0;
                    r_af_phase[p] <= 1'b1;
                end else if (vsync && !r_vs_prev) begin
                    if (r_af_cnt[p] == AW'(AUTOFIRE_FRAMES - 1)) begin
                        r_af_cnt[p]   <= '0;
                        r_af_phase[p] <= ~r_af_phase[p];
                    end else begin
                        r_af_cnt[p] <= r_af_cnt[p] + AW'(1);
                    end
                end
            end
        end
    end
`endif

    always_comb begin
        w_ctrl_next = w_raw;
        w_pause_any = 1'b0;
        for (int p = 0; p < PLAYERS; p++) begin
            w_ctrl_next[p*J+B_COIN] = (r_coin_cnt[p] != '0) || w_raw[p*J+B_COIN];
            w_pause_any = w_pause_any | w_raw[p*J+B_PAUSE];
`ifdef AUTOFIRE_EN
            if (autofire[p])
                w_ctrl_next[p*J+B_FIRE] = w_raw[p*J+B_FIRE] & r_af_phase[p];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl       <= '0;
            r_pause      <= 1'b0;
            r_pause_prev <= 1'b0;
            r_coin_prev  <= '0;
            for (int p = 0; p < PLAYERS; p++) r_coin_cnt[p] <= '0;
        end else begin
            r_ctrl       <= w_ctrl_next;
            r_pause_prev <= w_pause_any;
            if (w_pause_any && !r_pause_prev)
                r_pause <= ~r_pause;
            for (int p = 0; p < PLAYERS; p++) begin
                r_coin_prev[p] <= w_raw[p*J+B_COIN];
                if (w_raw[p*J+B_COIN] && !r_coin_prev[p])
                    r_coin_cnt[p] <= CW'(COIN_CYCLES - 1);
                else if (r_coin_cnt[p] != '0)
                    r_coin_cnt[p] <= r_coin_cnt[p] - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb/tb_arcade_input_mapper.sv - directed scoreboard bench for arcade_input_mapper
module tb_arcade_input_mapper;
    localparam int PLAYERS = 2;
    localparam int BUTTONS = 3;
    localparam int J       = BUTTONS + 7;
    localparam int N       = PLAYERS * J;

    logic          clk = 1'b0;
    logic          reset;
    logic [10:0]   ps2_key;
    logic [N-1:0]  joy_in;
    logic          ioctl_wr;
    logic [7:0]    ioctl_index;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_data;
    logic          vsync;
    logic [N-1:0]  ctrl_out;
    logic          pause;
    logic [3:0]    game_index;
    logic [63:0]   dip_out;

    arcade_input_mapper #(
        .PLAYERS(PLAYERS), .BUTTONS(BUTTONS), .DIP_BYTES(8),
        .COIN_CYCLES(100), .KEYMAP_INDEX(253)
    ) dut (
        .clk(clk), .reset(reset), .ps2_key(ps2_key), .joy_in(joy_in),
        .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
        .ioctl_data(ioctl_data), .vsync(vsync),
`ifdef AUTOFIRE_EN
        .autofire('0),
`endif
        .ctrl_out(ctrl_out), .pause(pause), .game_index(game_index), .dip_out(dip_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic tgl = 1'b0;
    int   first_hi;
    int   hi_cnt;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_val(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check_next(input logic [63:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_underflow observed=%0h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic key(input logic [7:0] code, input logic pressed);
        tgl     = ~tgl;
        ps2_key = {tgl, pressed, 1'b0, code};
    endtask

    task automatic ioctl(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
        ioctl_index = idx;
        ioctl_addr  = addr;
        ioctl_data  = data;
        ioctl_wr    = 1'b1;
        tick(1);
        ioctl_wr    = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ps2_key = '0; joy_in = '0; ioctl_wr = 1'b0;
        ioctl_index = '0; ioctl_addr = '0; ioctl_data = '0; vsync = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);

        expect_val("reset_ctrl", 64'h0);   check_next(64'(ctrl_out));
        expect_val("reset_pause", 64'h0);  check_next(64'(pause));
        expect_val("reset_game", 64'h0);   check_next(64'(game_index));
        expect_val("reset_dip", 64'h0);    check_next(dip_out);

        // Key 0x14 -> P1 button 1, visible on the second edge.
        key(8'h14, 1'b1);
        expect_val("key14_edge1", 64'h0);
        expect_val("key14_edge2", 64'h10);
        tick(1); check_next(64'(ctrl_out));
        tick(1); check_next(64'(ctrl_out));
        key(8'h14, 1'b0);
        expect_val("key14_release", 64'h0);
        tick(2); check_next(64'(ctrl_out));

        // P2 default map and unmapped code 0x00.
        key(8'h1C, 1'b1);
        expect_val("key1c_p2_button1", 64'h1 << 14);
        tick(2); check_next(64'(ctrl_out));
        key(8'h1C, 1'b0);
        tick(2);
        key(8'h00, 1'b1);
        expect_val("code00_ctrl", 64'h0);
        expect_val("code00_pause", 64'h0);
        tick(3); check_next(64'(ctrl_out)); check_next(64'(pause));

        joy_in[1*J+7] = 1'b1;
        expect_val("joy_p2_start", 64'h1 << 17);
        tick(1); check_next(64'(ctrl_out));
        joy_in = '0;
        expect_val("joy_release", 64'h0);
        tick(1); check_next(64'(ctrl_out));

        // Coin stretch via key 0x2E held for 10 cycles.
        key(8'h2E, 1'b1);
        expect_val("coin_first_rise", 64'd2);
        expect_val("coin_high_cycles", 64'd100);
        first_hi = -1;
        hi_cnt   = 0;
        for (int t = 1; t <= 300; t++) begin
            @(negedge clk);
            if (ctrl_out[8]) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = t;
            end
            if (t == 10) key(8'h2E, 1'b0);
        end
        check_next(64'(first_hi));
        check_next(64'(hi_cnt));

        // Reset in the middle of a joystick-driven stretch.
        joy_in[8] = 1'b1;
        tick(1);
        joy_in = '0;
        expect_val("coin_mid_stretch", 64'h100);
        tick(5); check_next(64'(ctrl_out));
        reset = 1'b1;
        expect_val("coin_reset_kill", 64'h0);
        tick(1); check_next(64'(ctrl_out));
        reset = 1'b0;
        expect_val("coin_after_reset", 64'h0);
        tick(1); check_next(64'(ctrl_out));

        // Pause toggle on key 0x4D.
        key(8'h4D, 1'b1);
        expect_val("pause_press1", 64'h1);
        expect_val("pause_bit_pass", 64'h200);
        tick(2); check_next(64'(pause)); check_next(64'(ctrl_out));
        key(8'h4D, 1'b0);
        expect_val("pause_release1", 64'h1);
        tick(2); check_next(64'(pause));
        key(8'h4D, 1'b1);
        expect_val("pause_press2", 64'h0);
        tick(2); check_next(64'(pause));
        key(8'h4D, 1'b0);
        tick(2);
        key(8'h4D, 1'b1);
        expect_val("pause_press3", 64'h1);
        tick(2); check_next(64'(pause));
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        expect_val("pause_reset", 64'h0);
        tick(1); check_next(64'(pause));
        key(8'h4D, 1'b0);
        tick(2);

        // Remap P1 button 1 to 0x1A while 0x14 is held.
        key(8'h14, 1'b1);
        expect_val("remap_held", 64'h10);
        tick(2); check_next(64'(ctrl_out));
        ioctl(8'd253, 25'd4, 8'h1A);
        expect_val("remap_cleared", 64'h0);
        tick(1); check_next(64'(ctrl_out));
        key(8'h1A, 1'b1);
        expect_val("remap_new_code", 64'h10);
        tick(2); check_next(64'(ctrl_out));
        key(8'h1A, 1'b0);
        tick(2);
        key(8'h14, 1'b1);
        expect_val("remap_old_code", 64'h0);
        tick(2); check_next(64'(ctrl_out));
        key(8'h14, 1'b0);
        tick(2);

        // DIP bytes and game index.
        ioctl(8'd254, 25'd0, 8'hA5);
        ioctl(8'd254, 25'd1, 8'h3C);
        ioctl(8'd254, 25'd9, 8'hFF);
        ioctl(8'd254, 25'd8, 8'hEE);
        ioctl(8'd1, 25'd0, 8'h07);
        expect_val("dip_bytes", 64'h3CA5);
        expect_val("game_index", 64'h7);
        tick(1); check_next(dip_out); check_next(64'(game_index));
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        expect_val("game_after_reset", 64'h7);
        expect_val("dip_after_reset", 64'h3CA5);
        tick(1); check_next(64'(game_index)); check_next(dip_out);

        // Key event coinciding with a keymap write is discarded.
        ioctl(8'd253, 25'd4, 8'h14);
        tick(1);
        key(8'h74, 1'b1);
        expect_val("collide_pre_held", 64'h1);
        tick(2); check_next(64'(ctrl_out));
        key(8'h14, 1'b1);
        ioctl_index = 8'd253; ioctl_addr = 25'd4; ioctl_data = 8'h14; ioctl_wr = 1'b1;
        tick(1);
        ioctl_wr = 1'b0;
        expect_val("collide_cleared", 64'h0);
        expect_val("collide_event_lost", 64'h0);
        tick(1); check_next(64'(ctrl_out));
        tick(3); check_next(64'(ctrl_out));
        key(8'h14, 1'b0);
        key(8'h74, 1'b0);
        tick(2);

        // One code mapped to two controls.
        ioctl(8'd253, 25'd10, 8'h74);
        key(8'h74, 1'b1);
        expect_val("dup_code", 64'h401);
        tick(2); check_next(64'(ctrl_out));
        key(8'h74, 1'b0);
        expect_val("dup_release", 64'h0);
        tick(2); check_next(64'(ctrl_out));

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
